// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
//   Sequencing controller around an N-bit, one-position-per-clock shift
//   register. A command (operand, amount, mode) is accepted over a
//   valid/ready handshake, the operand is stepped one position per clock
//   for the effective amount, and the result is held on a valid/ready port
//   until the consumer takes it.
//
// Ports
//   clk        clock, all state updates on posedge
//   clr        synchronous reset, active-high
//   cmd_valid  command present
//   cmd_ready  block can accept a command (IDLE and not in reset)
//   cmd_data   operand, N bits
//   cmd_amt    requested shift amount, unsigned, CW bits
//   cmd_mode   000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR, others illegal
//   abort      cancel an in-progress shift (only honoured in SHIFT)
//   res_valid  result available (state DONE)
//   res_ready  consumer accepts result
//   res_data   shift register contents; qualify with res_valid
//   res_err    result came from an illegal mode; valid with res_valid
//   busy       high in SHIFT or DONE
module shift_seq_ctrl #(
    parameter int N  = 32,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [N-1:0]  cmd_data,
    input  logic [CW-1:0] cmd_amt,
    input  logic [2:0]    cmd_mode,
    input  logic          abort,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [N-1:0]  res_data,
    output logic          res_err,
    output logic          busy
);

    localparam int LG = $clog2(N);

    localparam logic [2:0] M_LSL = 3'b000;
    localparam logic [2:0] M_LSR = 3'b001;
    localparam logic [2:0] M_ASR = 3'b010;
    localparam logic [2:0] M_ROL = 3'b011;
    localparam logic [2:0] M_ROR = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  q, q_step;
    logic [CW-1:0] cnt;
    logic [2:0]    mode_q;
    logic          err_q;

    logic          accept;
    logic          illegal;
    logic [CW-1:0] eff;

    assign cmd_ready = (state == IDLE) && !clr;
    assign accept    = cmd_valid && cmd_ready;
    assign res_valid = (state == DONE);
    assign res_data  = q;
    assign res_err   = err_q;
    assign busy      = (state != IDLE);
    assign illegal   = (cmd_mode > M_ROR);

    // Effective amount. The clamp compares the full-width amount so upper
    // bits are honoured; rotates only need the low LG bits (mod N, N is a
    // power of two).
    always_comb begin
        eff = '0;
        if (illegal)
            eff = '0;
        else if (cmd_mode == M_ROL || cmd_mode == M_ROR)
            eff = {{(CW-LG){1'b0}}, cmd_amt[LG-1:0]};
        else if (cmd_amt > CW'(N))
            eff = CW'(N);
        else
            eff = cmd_amt;
    end

    // One-position step for the latched mode.
    always_comb begin
        q_step = q;
        case (mode_q)
            M_LSL:   q_step = {q[N-2:0], 1'b0};
            M_LSR:   q_step = {1'b0, q[N-1:1]};
            M_ASR:   q_step = {q[N-1], q[N-1:1]};
            M_ROL:   q_step = {q[N-2:0], q[N-1]};
            M_ROR:   q_step = {q[0], q[N-1:1]};
            default: q_step = q;
        endcase
    end

    // Next-state logic. abort beats the final shift edge.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (eff != '0) ? SHIFT : DONE;
            SHIFT: begin
                if (abort)
                    state_nxt = IDLE;
                else if (cnt == CW'(1))
                    state_nxt = DONE;
            end
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            q      <= '0;
            cnt    <= '0;
            mode_q <= M_LSL;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                q      <= cmd_data;
                cnt    <= eff;
                mode_q <= cmd_mode;
                err_q  <= illegal;
            end else if (state == SHIFT) begin
                // On abort the partial value is left in place; it is never
                // presented as a result.
                if (abort) begin
                    cnt <= '0;
                end else begin
                    q   <= q_step;
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases followed by random
// commands, compared against an arithmetic reference model.
module tb_shift_seq_ctrl;

    localparam int N  = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          clr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [N-1:0]  cmd_data;
    logic [CW-1:0] cmd_amt;
    logic [2:0]    cmd_mode;
    logic          abort;
    logic          res_valid;
    logic          res_ready;
    logic [N-1:0]  res_data;
    logic          res_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    shift_seq_ctrl #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_amt   (cmd_amt),
        .cmd_mode  (cmd_mode),
        .abort     (abort),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: amount rules and shift results as plain arithmetic.
    function automatic int model_eff(input int amt, input int mode);
        if (mode > 4)       return 0;
        else if (mode >= 3) return amt % N;
        else                return (amt > N) ? N : amt;
    endfunction

    function automatic logic [31:0] model_res(input logic [31:0] d, input int eff, input int mode);
        logic [63:0]        w;
        logic signed [63:0] s;
        logic [63:0]        t;
        w = {32'd0, d};
        s = $signed({{32{d[31]}}, d});
        case (mode)
            0: begin t = w << eff;       return t[31:0];  end
            1: begin t = w >> eff;       return t[31:0];  end
            2: begin t = s >>> eff;      return t[31:0];  end
            3: begin t = {d, d} << eff;  return t[63:32]; end
            4: begin t = {d, d} >> eff;  return t[31:0];  end
            default: return d;
        endcase
    endfunction

    // Issue one command from a negedge in IDLE. kill_at > 0 asserts abort
    // (use_clr=0) or clr (use_clr=1) for the kill_at-th SHIFT edge.
    task automatic run_cmd(input logic [31:0] d, input int a, input int m,
                           input int kill_at, input bit use_clr, input int hold);
        int          eff;
        int          c;
        logic [31:0] er;
        logic        ee;
        eff = model_eff(a, m);
        er  = model_res(d, eff, m);
        ee  = (m > 4);

        chk("acc_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_data = d; cmd_amt = CW'(a); cmd_mode = 3'(m);
        abort     = 1'($urandom_range(0, 1));   // ignored in IDLE
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0; cmd_data = $urandom;
        cmd_amt = CW'($urandom); cmd_mode = 3'($urandom);

        if (kill_at > 0) begin
            repeat (kill_at - 1) begin
                chk("pre_kill_busy", busy, 1);
                @(negedge clk);
            end
            if (use_clr) clr = 1'b1; else abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            if (use_clr) begin
                chk("clr_ready", cmd_ready, 0);
                chk("clr_data", res_data, 0);
                clr = 1'b0;
            end
            chk("kill_valid", res_valid, 0);
            chk("kill_busy", busy, 0);
            repeat (2) begin
                @(negedge clk);
                chk("kill_quiet", res_valid, 0);
            end
            chk("kill_ready", cmd_ready, 1);
            return;
        end

        c = 0;
        while (!res_valid && c < 200) begin
            chk("shift_busy", busy, 1);
            chk("shift_ready", cmd_ready, 0);
            @(negedge clk);
            c++;
        end
        chk("latency", 64'(c), 64'(eff));
        chk("data", res_data, er);
        chk("err", res_err, ee);
        chk("done_busy", busy, 1);

        repeat (hold) begin
            res_ready = 1'b0;
            abort     = 1'($urandom_range(0, 1));   // ignored in DONE
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, er);
            chk("hold_err", res_err, ee);
            chk("hold_ready", cmd_ready, 0);
        end
        abort = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("rel_valid", res_valid, 0);
        chk("rel_busy", busy, 0);
        chk("rel_ready", cmd_ready, 1);
    endtask

    initial begin
        int          m, a, e, k;
        logic [31:0] d;
        clr = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_amt = '0;
        cmd_mode = '0; abort = 1'b0; res_ready = 1'b0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", cmd_ready, 0);
            chk("rst_data", res_data, 0);
        end
        clr = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1);

        run_cmd(32'h0000_0001, 4,  0, 0, 0, 0);   // LSL
        run_cmd(32'h0000_0001, 33, 4, 0, 0, 1);   // ROR, eff=1
        run_cmd(32'h8000_0000, 40, 2, 0, 0, 0);   // ASR clamp
        run_cmd(32'hDEAD_BEEF, 0,  1, 0, 0, 0);   // LSR amt 0
        run_cmd(32'h0000_00F0, 4,  1, 0, 0, 5);   // backpressure
        run_cmd(32'h1234_5678, 16, 3, 5, 0, 0);   // abort at 5th SHIFT edge
        run_cmd(32'h1234_5678, 16, 3, 10, 1, 0);  // clr at 10th SHIFT edge
        run_cmd(32'hCAFE_F00D, 7,  7, 0, 0, 2);   // illegal mode
        run_cmd(32'h0000_0003, 1,  0, 0, 0, 0);   // legal clears err
        run_cmd(32'h0000_0001, 3,  3, 3, 0, 0);   // abort on final edge
        run_cmd(32'hFFFF_0000, 63, 0, 0, 0, 0);   // LSL clamp to zero
        run_cmd(32'hA5A5_A5A5, 32, 3, 0, 0, 0);   // ROL 32 -> eff 0

        for (int i = 0; i < 80; i++) begin
            d = $urandom;
            m = $urandom_range(0, 7);
            a = $urandom_range(0, 63);
            e = model_eff(a, m);
            k = 0;
            if (e > 0 && $urandom_range(0, 9) == 0) k = $urandom_range(1, e);
            run_cmd(d, a, m, k, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
